// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the register-file dump/clear controller.
//   ADDR_W   : register address width
//   DATA_W   : register data width
//   NUM_REGS : registers walked by one operation (2**ADDR_W)
//   IDX_W    : walk counter width, one bit wider than ADDR_W so the counter
//              can represent NUM_REGS without wrapping
//   state_t  : controller state encoding
//   MODE_*   : values of the mode input sampled with start
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int IDX_W    = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DUMP  = 3'd1,
        DRAIN = 3'd2,
        CLEAR = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic MODE_DUMP  = 1'b0;
    localparam logic MODE_CLEAR = 1'b1;

endpackage

// File: rtl/rf_stream_slot.sv
// -----------------------------------------------------------------------------
// rf_stream_slot
// Single-entry output register for the debug stream. A load captures a new
// beat and raises m_valid; without a load, a completed handshake empties the
// slot. While m_valid && !m_ready the payload is frozen.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   load                 : capture load_* this cycle (caller guarantees the
//                          slot is empty or being emptied)
//   load_data/addr/last  : beat to capture
//   m_ready              : sink ready
//   m_valid/data/addr/last : registered stream outputs
// -----------------------------------------------------------------------------
module rf_stream_slot
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              load_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last
);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload flops are reset too, not just m_valid, because
            // the stream outputs are observable and must read zero after reset.
            m_valid <= 1'b0;
            m_data  <= '0;
            m_addr  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_addr  <= load_addr;
            m_last  <= load_last;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Maintenance controller that owns the register file ports while active.
// Dump mode walks read port A1 over every register and streams the values
// out in ascending index order; clear mode walks write port A3 and zeroes
// every register (index 0 included). hold stalls the core meanwhile.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, mode     : one-cycle request and its mode, sampled only in IDLE
//   busy, hold      : high whenever not IDLE (hold mirrors busy)
//   done            : one-cycle pulse when an operation completes
//   rf_ra / rf_rd   : register file read address / combinational read data
//   rf_we/wa/wd     : register file write enable / address / data
//   m_valid/ready   : stream handshake
//   m_data/addr/last: stream beat payload, last flags index NUM_REGS-1
// -----------------------------------------------------------------------------
module regfile_dump_ctrl
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              hold,
    output logic              done,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last
);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic              last_idx;
    logic              load;
    logic              handshake;

    // Compare against the final index explicitly; the extra idx bit exists so
    // the walk never depends on counter wrap-around.
    assign last_idx  = (idx == IDX_W'(NUM_REGS - 1));
    assign handshake = m_valid && m_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Walk counter: restarts at 0 from IDLE, advances on every stream load in
    // DUMP and on every cycle in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else begin
            case (state)
                IDLE:    idx <= '0;
                DUMP:    if (load) idx <= idx + 1'b1;
                CLEAR:   idx <= idx + 1'b1;
                default: idx <= idx;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: a default assignment ahead of the case keeps every path
        // assigned, so no latch is inferred for state_next.
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (mode == MODE_DUMP) ? DUMP : CLEAR;
                end
            end
            DUMP:    if (load && last_idx) state_next = DRAIN;
            DRAIN:   if (handshake) state_next = FIN;
            CLEAR:   if (last_idx) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state != IDLE);
        hold  = busy;
        done  = (state == FIN);
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        rf_ra = '0;
        load  = 1'b0;
        case (state)
            DUMP: begin
                rf_ra = idx[ADDR_W-1:0];
                // The slot can take a new beat when empty or when its current
                // beat leaves on this edge.
                load  = !m_valid || m_ready;
            end
            CLEAR: begin
                rf_we = 1'b1;
                rf_wa = idx[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    rf_stream_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (rf_rd),
        .load_addr (idx[ADDR_W-1:0]),
        .load_last (last_idx),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_addr    (m_addr),
        .m_last    (m_last)
    );

endmodule
